// File: rtl/ps2_receive_pkg.sv
// -----------------------------------------------------------------------------
// ps2_receive_pkg
// Shared definitions for the PS/2 device-to-host receiver:
//   - receiver state codes
//   - error cause codes reported on errCode
//   - PS/2 frame geometry (start + 8 data + parity + stop = 11 bits)
//   - odd-parity helper
// No ports; imported by ps2_receive and ps2_line_filter.
// -----------------------------------------------------------------------------
package ps2_receive_pkg;

    typedef enum logic [1:0] {
        ST_RX_IDLE  = 2'd0,
        ST_RX_RECV  = 2'd1,
        ST_RX_CHECK = 2'd2
    } rx_state_t;

    localparam logic [1:0] ERR_START   = 2'b00;
    localparam logic [1:0] ERR_PARITY  = 2'b01;
    localparam logic [1:0] ERR_STOP    = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT = 2'b11;

    localparam int PS2_FRAME_LEN = 11;

    // Bit index within the frame (start bit = 0) as counted by nbits.
    localparam logic [3:0] PARITY_BIT_IDX = 4'(PS2_FRAME_LEN - 2);
    localparam logic [3:0] STOP_BIT_IDX   = 4'(PS2_FRAME_LEN - 1);

    // Odd parity holds when the 8 data bits plus the parity bit contain
    // an odd number of ones.
    function automatic logic odd_parity_ok(input logic [8:0] bits);
        return ^bits;
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// -----------------------------------------------------------------------------
// ps2_line_filter
// 2-FF synchroniser followed by a glitch filter for one PS/2 line.
// The filtered value changes only after FILTER_LEN consecutive synchronised
// samples that differ from it.
// Ports:
//   qzt_clk  in  system clock
//   reset    in  synchronous active-high reset (line loads 1, bus idle-high)
//   din      in  raw asynchronous pin
//   dout     out filtered line value
// -----------------------------------------------------------------------------
module ps2_line_filter
    import ps2_receive_pkg::*;
#(
    parameter int FILTER_LEN = 8
) (
    input  logic qzt_clk,
    input  logic reset,
    input  logic din,
    output logic dout
);

    localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_LEN - 1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_filt;
    logic [CW-1:0] r_cnt;
    logic          w_flip;

    // The FILTER_LEN-th differing sample is sitting in r_sync2 right now.
    assign w_flip = (r_sync2 != r_filt) && (r_cnt == CNT_LAST);

    // dout shows the new level in the same cycle the flip is decided, so the
    // consumer's registers change on the same edge as r_filt; this keeps the
    // pin-to-state latency at 2 + FILTER_LEN cycles.
    assign dout = w_flip ? r_sync2 : r_filt;

    always_ff @(posedge qzt_clk) begin
        if (reset) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_filt  <= 1'b1;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= din;
            r_sync2 <= r_sync1;
            if (r_sync2 == r_filt) begin
                r_cnt <= '0;
            end else if (w_flip) begin
                r_filt <= r_sync2;
                r_cnt  <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ps2_receive.sv
// -----------------------------------------------------------------------------
// ps2_receive
// PS/2 device-to-host receiver. Frames: start(0), 8 data bits LSB first,
// odd parity, stop(1). Data is sampled on each falling edge of the filtered
// PS/2 clock.
// Ports:
//   qzt_clk  in   system clock (only clock)
//   reset    in   synchronous active-high reset
//   PS2C     in   raw PS/2 clock pin (asynchronous)
//   PS2D     in   raw PS/2 data pin (asynchronous)
//   inhibit  in   host sender owns the bus; receiver forced idle and silent
//   data     out  last good byte, held until the next good frame
//   valid    out  1-cycle strobe: data updated
//   err      out  1-cycle strobe: frame rejected
//   errCode  out  cause of last err (00 start, 01 parity, 10 stop, 11 timeout)
//   busy     out  frame in progress
// -----------------------------------------------------------------------------
module ps2_receive
    import ps2_receive_pkg::*;
#(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 10000
) (
    input  logic       qzt_clk,
    input  logic       reset,
    input  logic       PS2C,
    input  logic       PS2D,
    input  logic       inhibit,
    output logic [7:0] data,
    output logic       valid,
    output logic       err,
    output logic [1:0] errCode,
    output logic       busy
);

    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);
    localparam logic [TO_W-1:0] TO_MAX  = TO_W'(TIMEOUT_CYC);

    // ------------------------------------------------------------------
    // Input conditioning: index 0 = clock line, index 1 = data line
    // ------------------------------------------------------------------
    logic [1:0] w_raw;
    logic [1:0] w_filt;
    logic       w_ps2c;
    logic       w_ps2d;

    assign w_raw = {PS2D, PS2C};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_line
            ps2_line_filter #(
                .FILTER_LEN (FILTER_LEN)
            ) u_filter (
                .qzt_clk (qzt_clk),
                .reset   (reset),
                .din     (w_raw[gi]),
                .dout    (w_filt[gi])
            );
        end
    endgenerate

    assign w_ps2c = w_filt[0];
    assign w_ps2d = w_filt[1];

    // ------------------------------------------------------------------
    // Fall event detection; ignored entirely while the sender owns the bus
    // ------------------------------------------------------------------
    logic r_ps2c_prev;
    logic w_fall;

    assign w_fall = r_ps2c_prev & ~w_ps2c & ~inhibit;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    rx_state_t       r_state;
    rx_state_t       w_state_next;
    logic [3:0]      r_nbits;
    logic [8:0]      r_shift;
    logic            r_stop;
    logic [TO_W-1:0] r_to_cnt;
    logic            w_timeout;

    logic [7:0]      r_data;
    logic            r_valid;
    logic            r_err;
    logic [1:0]      r_err_code;

    logic [7:0]      w_data_next;
    logic            w_valid_next;
    logic            w_err_next;
    logic [1:0]      w_err_code_next;

    assign w_timeout = (r_to_cnt >= TO_LAST);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge qzt_clk) begin
        if (reset) begin
            r_state <= ST_RX_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        if (inhibit) begin
            w_state_next = ST_RX_IDLE;
        end else begin
            case (r_state)
                ST_RX_IDLE: begin
                    if (w_fall && !w_ps2d) begin
                        w_state_next = ST_RX_RECV;
                    end
                end
                ST_RX_RECV: begin
                    // A fall on the timeout cycle wins: the frame continues.
                    if (w_fall) begin
                        if (r_nbits == STOP_BIT_IDX) begin
                            w_state_next = ST_RX_CHECK;
                        end
                    end else if (w_timeout) begin
                        w_state_next = ST_RX_IDLE;
                    end
                end
                ST_RX_CHECK: begin
                    w_state_next = ST_RX_IDLE;
                end
                default: begin
                    w_state_next = ST_RX_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // FSM: output logic (strobes and data are registered below)
    // ------------------------------------------------------------------
    always_comb begin
        w_data_next     = r_data;
        w_valid_next    = 1'b0;
        w_err_next      = 1'b0;
        w_err_code_next = r_err_code;
        if (!inhibit) begin
            case (r_state)
                ST_RX_IDLE: begin
                    if (w_fall && w_ps2d) begin
                        w_err_next      = 1'b1;
                        w_err_code_next = ERR_START;
                    end
                end
                ST_RX_RECV: begin
                    if (!w_fall && w_timeout) begin
                        w_err_next      = 1'b1;
                        w_err_code_next = ERR_TIMEOUT;
                    end
                end
                ST_RX_CHECK: begin
                    // Stop bit is judged before parity.
                    if (!r_stop) begin
                        w_err_next      = 1'b1;
                        w_err_code_next = ERR_STOP;
                    end else if (!odd_parity_ok(r_shift)) begin
                        w_err_next      = 1'b1;
                        w_err_code_next = ERR_PARITY;
                    end else begin
                        w_valid_next = 1'b1;
                        w_data_next  = r_shift[7:0];
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge qzt_clk) begin
        if (reset) begin
            r_data     <= '0;
            r_valid    <= 1'b0;
            r_err      <= 1'b0;
            r_err_code <= ERR_START;
        end else begin
            r_data     <= w_data_next;
            r_valid    <= w_valid_next;
            r_err      <= w_err_next;
            r_err_code <= w_err_code_next;
        end
    end

    // ------------------------------------------------------------------
    // Datapath: bit counter, shift register, stop bit, timeout counter
    // ------------------------------------------------------------------
    always_ff @(posedge qzt_clk) begin
        if (reset) begin
            r_ps2c_prev <= 1'b1;
            r_nbits     <= '0;
            r_shift     <= '0;
            r_stop      <= 1'b0;
            r_to_cnt    <= '0;
        end else begin
            r_ps2c_prev <= w_ps2c;
            if (inhibit) begin
                r_nbits  <= '0;
                r_to_cnt <= '0;
            end else begin
                case (r_state)
                    ST_RX_IDLE: begin
                        r_to_cnt <= '0;
                        r_nbits  <= (w_fall && !w_ps2d) ? 4'd1 : 4'd0;
                    end
                    ST_RX_RECV: begin
                        if (w_fall) begin
                            r_to_cnt <= '0;
                            r_nbits  <= r_nbits + 4'd1;
                            // Right shift: after bits 1..9 the first data
                            // bit lands in [0] and parity in [8].
                            if (r_nbits <= PARITY_BIT_IDX) begin
                                r_shift <= {w_ps2d, r_shift[8:1]};
                            end else begin
                                r_stop <= w_ps2d;
                            end
                        end else if (r_to_cnt != TO_MAX) begin
                            r_to_cnt <= r_to_cnt + 1'b1;
                        end
                    end
                    default: begin
                        r_nbits  <= '0;
                        r_to_cnt <= '0;
                    end
                endcase
            end
        end
    end

    assign data    = r_data;
    assign valid   = r_valid;
    assign err     = r_err;
    assign errCode = r_err_code;
    assign busy    = (r_state != ST_RX_IDLE);

endmodule

// File: tb/tb_ps2_receive.sv
// -----------------------------------------------------------------------------
// tb_ps2_receive
// Directed-vector bench for ps2_receive. Frames are driven bit by bit on
// PS2C/PS2D; a negedge monitor counts valid/err strobes and records the
// byte, code and timestamp of the last strobe.
// -----------------------------------------------------------------------------
module tb_ps2_receive;

    localparam int FILTER_LEN  = 8;
    localparam int TIMEOUT_CYC = 300;
    localparam int HALF        = 20;   // PS2C half period in qzt_clk cycles

    logic       qzt_clk = 1'b0;
    logic       reset   = 1'b1;
    logic       PS2C    = 1'b1;
    logic       PS2D    = 1'b1;
    logic       inhibit = 1'b0;
    logic [7:0] data;
    logic       valid;
    logic       err;
    logic [1:0] errCode;
    logic       busy;

    ps2_receive #(
        .FILTER_LEN  (FILTER_LEN),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .qzt_clk (qzt_clk),
        .reset   (reset),
        .PS2C    (PS2C),
        .PS2D    (PS2D),
        .inhibit (inhibit),
        .data    (data),
        .valid   (valid),
        .err     (err),
        .errCode (errCode),
        .busy    (busy)
    );

    always #5 qzt_clk = ~qzt_clk;

    int n_checks = 0;
    int n_errors = 0;

    int cyc = 0;
    int n_valid = 0;
    int n_err = 0;
    int n_both = 0;
    int last_err_cyc = 0;
    int t_last_fall = 0;
    logic [7:0] last_data = '0;

    always @(posedge qzt_clk) cyc <= cyc + 1;

    always @(negedge qzt_clk) begin
        if (valid) begin
            n_valid++;
            last_data = data;
        end
        if (err) begin
            n_err++;
            last_err_cyc = cyc;
        end
        if (valid && err) n_both++;
    end

    initial begin
        #300000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end else begin
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    task automatic clear_mon();
        n_valid = 0;
        n_err   = 0;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge qzt_clk);
    endtask

    // One PS/2 bit: data set during clock-high, fall after HALF cycles.
    // Optional 3-cycle low glitch in the following high phase.
    task automatic send_bit(input logic b, input bit glitch);
        @(negedge qzt_clk);
        PS2D = b;
        wait_cycles(HALF);
        PS2C = 1'b0;
        t_last_fall = cyc;
        wait_cycles(HALF);
        PS2C = 1'b1;
        if (glitch) begin
            wait_cycles(12);
            PS2C = 1'b0;
            wait_cycles(3);
            PS2C = 1'b1;
            wait_cycles(HALF - 15);
        end else begin
            wait_cycles(HALF);
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par, input logic stp,
                              input int glitch_bit);
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i], glitch_bit == i);
        send_bit(par, 1'b0);
        send_bit(stp, 1'b0);
        @(negedge qzt_clk);
        PS2D = 1'b1;
        wait_cycles(20);
    endtask

    task automatic run_frame(input string tag, input logic [7:0] d, input logic par,
                             input logic stp, input int glitch_bit,
                             input int ev, input int ee, input logic [1:0] ecode,
                             input logic [7:0] edata);
        clear_mon();
        send_frame(d, par, stp, glitch_bit);
        check_eq({tag, "_valid"}, n_valid, ev);
        check_eq({tag, "_err"}, n_err, ee);
        check_eq({tag, "_code"}, {30'd0, errCode}, {30'd0, ecode});
        check_eq({tag, "_data"}, {24'd0, data}, {24'd0, edata});
        $display("frame %s d=%02h par=%0d stop=%0d -> valid=%0d err=%0d code=%0d data=%02h",
                 tag, d, par, stp, n_valid, n_err, errCode, data);
    endtask

    initial begin
        logic [7:0] d3c;
        int w;
        d3c = 8'h3C;

        wait_cycles(5);
        @(negedge qzt_clk);
        reset = 1'b0;
        wait_cycles(2);
        check_eq("rst_data", {24'd0, data}, 32'h0);
        check_eq("rst_valid", {31'd0, valid}, 32'h0);
        check_eq("rst_err", {31'd0, err}, 32'h0);
        check_eq("rst_code", {30'd0, errCode}, 32'h0);
        check_eq("rst_busy", {31'd0, busy}, 32'h0);

        // tag, data, parity, stop, glitch bit, valid, err, code, data
        run_frame("fa",   8'hFA, 1'b1, 1'b1, -1, 1, 0, 2'b00, 8'hFA);
        check_eq("fa_last", {24'd0, last_data}, 32'hFA);
        run_frame("aa_par", 8'hAA, 1'b0, 1'b1, -1, 0, 1, 2'b01, 8'hFA);
        run_frame("55_stop", 8'h55, 1'b0, 1'b0, -1, 0, 1, 2'b10, 8'hFA);

        // Fall with data high while idle: bad start bit
        clear_mon();
        send_bit(1'b1, 1'b0);
        wait_cycles(20);
        check_eq("start_err", n_err, 1);
        check_eq("start_code", {30'd0, errCode}, 32'h0);
        check_eq("start_busy", {31'd0, busy}, 32'h0);
        $display("start-bit error -> err=%0d code=%0d", n_err, errCode);

        // Timeout: start + 4 data bits, then the clock stops
        clear_mon();
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0);
        check_eq("to_busy", {31'd0, busy}, 32'h1);
        w = 0;
        while (n_err == 0 && w < 2000) begin
            @(negedge qzt_clk);
            w++;
        end
        check_eq("to_err", n_err, 1);
        check_eq("to_code", {30'd0, errCode}, 32'h3);
        check_eq("to_lat", last_err_cyc - t_last_fall, 2 + FILTER_LEN + TIMEOUT_CYC);
        check_eq("to_busy_after", {31'd0, busy}, 32'h0);
        $display("timeout -> err=%0d code=%0d latency=%0d", n_err, errCode,
                 last_err_cyc - t_last_fall);

        run_frame("08", 8'h08, 1'b0, 1'b1, -1, 1, 0, 2'b11, 8'h08);
        run_frame("3c_glitch", 8'h3C, 1'b1, 1'b1, 3, 1, 0, 2'b11, 8'h3C);

        // Inhibit after bit 4 of a frame: rest of frame ignored
        clear_mon();
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) send_bit(d3c[i], 1'b0);
        check_eq("inh_busy_pre", {31'd0, busy}, 32'h1);
        @(negedge qzt_clk);
        inhibit = 1'b1;
        wait_cycles(2);
        check_eq("inh_busy", {31'd0, busy}, 32'h0);
        for (int i = 4; i < 8; i++) send_bit(d3c[i], 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        @(negedge qzt_clk);
        PS2D = 1'b1;
        inhibit = 1'b0;
        wait_cycles(30);
        check_eq("inh_valid", n_valid, 0);
        check_eq("inh_err", n_err, 0);
        check_eq("inh_busy_end", {31'd0, busy}, 32'h0);
        check_eq("inh_data", {24'd0, data}, 32'h3C);
        $display("inhibit frame -> valid=%0d err=%0d busy=%0d", n_valid, n_err, busy);

        // Reset in the middle of a later frame
        clear_mon();
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < 3; i++) send_bit(1'b1, 1'b0);
        check_eq("rst2_busy_pre", {31'd0, busy}, 32'h1);
        @(negedge qzt_clk);
        reset = 1'b1;
        PS2D  = 1'b1;
        @(negedge qzt_clk);
        reset = 1'b0;
        wait_cycles(30);
        check_eq("rst2_valid", n_valid, 0);
        check_eq("rst2_err", n_err, 0);
        check_eq("rst2_busy", {31'd0, busy}, 32'h0);
        check_eq("rst2_data", {24'd0, data}, 32'h0);
        check_eq("rst2_code", {30'd0, errCode}, 32'h0);
        $display("mid-frame reset -> data=%02h code=%0d busy=%0d", data, errCode, busy);

        check_eq("never_both", n_both, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
